// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and helpers for the UART receive path.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   // Clocks per bit period, truncated.
   function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq,
                                                input int unsigned uart_bps);
      return clk_freq / uart_bps;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module  : uart_rx_sync
// Brief   : Two-flop synchroniser for the RX pin plus 3-sample majority vote.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_sync
   import uart_pkg::*;
(
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic uart_rxd,
   output logic rxd_s,
   output logic rxd_maj
);

   logic       r_meta;
   logic [2:0] r_hist;

   // Reset to the idle-high line level so no false start follows reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_meta <= 1'b1;
         rxd_s  <= 1'b1;
         r_hist <= 3'b111;
      end else begin
         r_meta <= uart_rxd;
         rxd_s  <= r_meta;
         r_hist <= {r_hist[1:0], rxd_s};
      end
   end

   assign rxd_maj = (r_hist[0] & r_hist[1]) |
                    (r_hist[0] & r_hist[2]) |
                    (r_hist[1] & r_hist[2]);

endmodule

`default_nettype wire

// File: rtl/uart_recv.sv
// ============================================================================
// Module  : uart_recv
// Brief   : 8N1 UART receiver with mid-bit majority sampling and a one-entry
//           valid/ready holding register. Define UART_RX_PARITY_EN for 8E1.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_recv
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned UART_BPS = 9600
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              uart_rxd,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              frame_err,
   output logic              overrun,
   output logic              parity_err,
   output logic              rx_busy
);

   localparam int unsigned BPS_CNT    = calc_bps_cnt(CLK_FREQ, UART_BPS);
   localparam int unsigned MID_CNT    = BPS_CNT / 2;
   localparam logic [15:0] c_cnt_last = 16'(BPS_CNT - 1);
   localparam logic [15:0] c_cnt_mid  = 16'(MID_CNT);
   localparam logic [2:0]  c_bit_last = 3'(DATA_W - 1);

   logic              w_rxd_s;
   logic              w_maj;
   uart_state_t       r_state;
   uart_state_t       w_state_nxt;
   logic [15:0]       r_clk_cnt;
   logic [2:0]        r_bit_cnt;
   logic              r_armed;
   logic [DATA_W-1:0] r_shreg;
   logic              w_cnt_mid;
   logic              w_data_mid;
   logic              w_stop_mid;
   logic              w_par_ok;
   logic              w_complete;
   logic              w_load;
`ifdef UART_RX_PARITY_EN
   logic              w_par_mid;
   logic              r_par_bit;
`endif

   uart_rx_sync u_sync (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .uart_rxd  (uart_rxd),
      .rxd_s     (w_rxd_s),
      .rxd_maj   (w_maj)
   );

   assign w_cnt_mid = (r_clk_cnt == c_cnt_mid);
   assign rx_busy   = (r_state != IDLE);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_data_mid  = 1'b0;
      w_stop_mid  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_mid   = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (r_armed && !w_rxd_s) w_state_nxt = START;
         end
         START: begin
            if (w_cnt_mid) w_state_nxt = w_maj ? IDLE : DATA;
         end
         DATA: begin
            if (w_cnt_mid) begin
               w_data_mid = 1'b1;
               if (r_bit_cnt == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = PARITY;
`else
                  w_state_nxt = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (w_cnt_mid) begin
               w_par_mid   = 1'b1;
               w_state_nxt = STOP;
            end
         end
`endif
         STOP: begin
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            if (w_cnt_mid) begin
               w_stop_mid  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_clk_cnt <= 16'd0;
      end else if (r_state == IDLE || w_state_nxt == IDLE) begin
         r_clk_cnt <= 16'd0;
      end else if (r_clk_cnt == c_cnt_last) begin
         r_clk_cnt <= 16'd0;
      end else begin
         r_clk_cnt <= r_clk_cnt + 16'd1;
      end
   end

   // A held-low line must return high before another start is accepted.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_armed <= 1'b0;
      end else if (r_state != IDLE || w_state_nxt != IDLE) begin
         r_armed <= 1'b0;
      end else if (w_rxd_s) begin
         r_armed <= 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_bit_cnt <= 3'd0;
         r_shreg   <= '0;
      end else if (r_state == START) begin
         r_bit_cnt <= 3'd0;
      end else if (w_data_mid) begin
         r_shreg[r_bit_cnt] <= w_maj;
         r_bit_cnt          <= r_bit_cnt + 3'd1;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)     r_par_bit <= 1'b0;
      else if (w_par_mid) r_par_bit <= w_maj;
   end

   assign w_par_ok = ~(^{r_shreg, r_par_bit});

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) parity_err <= 1'b0;
      else            parity_err <= w_stop_mid & w_maj & ~w_par_ok;
   end
`else
   assign w_par_ok   = 1'b1;
   assign parity_err = 1'b0;
`endif

   assign w_complete = w_stop_mid & w_maj & w_par_ok;
   assign w_load     = w_complete & (~rx_valid | rx_ready);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= w_stop_mid & ~w_maj;
         overrun   <= w_complete & rx_valid & ~rx_ready;
         if (w_load) begin
            rx_data  <= r_shreg;
            rx_valid <= 1'b1;
         end else if (rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_recv.sv
// ============================================================================
// Module  : tb_uart_recv
// Brief   : Self-checking bench for uart_recv (honours UART_RX_PARITY_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_recv;

   localparam int CLK_FREQ = 1600000;
   localparam int UART_BPS = 100000;
   localparam int BPS      = CLK_FREQ / UART_BPS;
   localparam int MID      = BPS / 2;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       uart_rxd  = 1'b1;
   logic       rx_ready  = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;
   logic       rx_busy;

   always #5 sys_clk = ~sys_clk;

   uart_recv #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .uart_rxd   (uart_rxd),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err),
      .rx_busy    (rx_busy)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int got_ferr = 0, got_ovr = 0, got_perr = 0, busy_rises = 0, valid_cycles = 0;
   int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
   bit prev_busy = 1'b0;
   bit hold_v = 1'b0;
   logic [7:0] hold_d = 8'h00;

   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         prev_busy <= 1'b0;
      end else begin
         if (rx_valid && rx_ready) got_q.push_back(rx_data);
         if (rx_valid)            valid_cycles <= valid_cycles + 1;
         if (frame_err)           got_ferr <= got_ferr + 1;
         if (overrun)             got_ovr  <= got_ovr + 1;
         if (parity_err)          got_perr <= got_perr + 1;
         if (rx_busy && !prev_busy) busy_rises <= busy_rises + 1;
         prev_busy <= rx_busy;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Frame-level reference: outcome of one frame given the consumer's readiness.
   task automatic model_frame(input logic [7:0] d, input bit stop_v, input bit par_ok);
      if (!stop_v)                  exp_ferr++;
      else if (PAR_EN && !par_ok)   exp_perr++;
      else if (rx_ready)            exp_q.push_back(d);
      else if (!hold_v) begin
         hold_v = 1'b1;
         hold_d = d;
      end else                      exp_ovr++;
   endtask

   task automatic idle(input int n);
      uart_rxd = 1'b1;
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic set_ready(input bit v);
      @(posedge sys_clk);
      #1 rx_ready = v;
      if (v && hold_v) begin
         exp_q.push_back(hold_d);
         hold_v = 1'b0;
      end
      @(negedge sys_clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop_v, input bit par_ok,
                             input int spike_bit);
      uart_rxd = 1'b0;
      repeat (BPS) @(negedge sys_clk);
      for (int i = 0; i < 8; i++) begin
         for (int c = 0; c < BPS; c++) begin
            uart_rxd = (spike_bit == i && c == 7) ? ~d[i] : d[i];
            @(negedge sys_clk);
         end
      end
      if (PAR_EN) begin
         uart_rxd = (^d) ^ ~par_ok;
         repeat (BPS) @(negedge sys_clk);
      end
      uart_rxd = stop_v;
      repeat (BPS) @(negedge sys_clk);
      model_frame(d, stop_v, par_ok);
   endtask

   task automatic check_stream(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, "_byte"}, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_frame_err"},  got_ferr, exp_ferr);
      check({tag, "_overrun"},    got_ovr,  exp_ovr);
      check({tag, "_parity_err"}, got_perr, exp_perr);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_data"},    rx_data,    8'h00);
      check({tag, "_rx_valid"},   rx_valid,   1'b0);
      check({tag, "_frame_err"},  frame_err,  1'b0);
      check({tag, "_overrun"},    overrun,    1'b0);
      check({tag, "_parity_err"}, parity_err, 1'b0);
      check({tag, "_rx_busy"},    rx_busy,    1'b0);
   endtask

   initial begin
      int n;
      int rises0;
      int vc0;
      logic [7:0] rd;
      bit rst_ok, rpo, rrdy;

      // Reset state
      repeat (3) @(negedge sys_clk);
      check_reset_outputs("reset");
      sys_rst_n = 1'b1;
      idle(10);

      // 1: basic byte with start and completion latency
      vc0 = valid_cycles;
      fork
         send_frame(8'hA5, 1'b1, 1'b1, -1);
         begin
            n = 0;
            while (!rx_busy && n < 20) begin
               @(negedge sys_clk);
               n++;
            end
            check("start_latency", n, 3);
            while (!rx_valid && n < 400) begin
               @(negedge sys_clk);
               n++;
            end
            check("valid_latency", n, 3 + 9 * BPS + MID + 1);
         end
      join
      idle(4);
      check("a5_busy_after", rx_busy, 1'b0);
      check("a5_valid_cycles", valid_cycles - vc0, 1);
      check_stream("a5");
      check_counts("a5");

      // 2: short low glitch while idle
      rises0 = busy_rises;
      uart_rxd = 1'b0;
      repeat (5) @(negedge sys_clk);
      idle(30);
      check("glitch_busy_rise", busy_rises - rises0, 1);
      check("glitch_busy_after", rx_busy, 1'b0);
      check_stream("glitch");
      check_counts("glitch");

      // 3: bad stop bit, then a held-low break, then a good byte
      rises0 = busy_rises;
      send_frame(8'h3C, 1'b0, 1'b1, -1);
      uart_rxd = 1'b0;
      repeat (40) @(negedge sys_clk);
      check("break_busy", rx_busy, 1'b0);
      idle(20);
      send_frame(8'h81, 1'b1, 1'b1, -1);
      idle(4);
      check("break_busy_rises", busy_rises - rises0, 2);
      check_stream("break");
      check_counts("break");

      // 4: consumer stalled, back-to-back bytes overrun the holding register
      set_ready(1'b0);
      send_frame(8'h11, 1'b1, 1'b1, -1);
      send_frame(8'h22, 1'b1, 1'b1, -1);
      idle(4);
      check("stall_valid", rx_valid, 1'b1);
      check("stall_data", rx_data, 8'h11);
      check_counts("stall");
      set_ready(1'b1);
      idle(2);
      check("stall_valid_drop", rx_valid, 1'b0);
      check_stream("stall");

      // 5: one-clock spike inside data bit 3
      send_frame(8'h00, 1'b1, 1'b1, 3);
      idle(4);
      check_stream("spike");
      check_counts("spike");

      // 6: asynchronous reset in the middle of data bit 4
      set_ready(1'b0);
      send_frame(8'hC3, 1'b1, 1'b1, -1);
      idle(4);
      check("prerst_valid", rx_valid, 1'b1);
      check("prerst_data", rx_data, 8'hC3);
      rd = 8'h5A;
      uart_rxd = 1'b0;
      repeat (BPS) @(negedge sys_clk);
      for (int i = 0; i < 4; i++) begin
         uart_rxd = rd[i];
         repeat (BPS) @(negedge sys_clk);
      end
      uart_rxd = rd[4];
      repeat (MID) @(negedge sys_clk);
      check("prerst_busy", rx_busy, 1'b1);
      sys_rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      hold_v = 1'b0;
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      idle(20);
      set_ready(1'b1);
      send_frame(8'h5A, 1'b1, 1'b1, -1);
      idle(4);
      check_stream("postrst");
      check_counts("postrst");

`ifdef UART_RX_PARITY_EN
      // Parity mismatch with good stop bit
      send_frame(8'h07, 1'b1, 1'b0, -1);
      idle(4);
      check("par_valid", rx_valid, 1'b0);
      check_stream("parity");
      check_counts("parity");
`endif

      // Randomised frames against the frame-level model
      for (int k = 0; k < 12; k++) begin
         rd     = 8'($urandom);
         rst_ok = ($urandom_range(0, 4) != 0);
         rpo    = PAR_EN ? ($urandom_range(0, 3) != 0) : 1'b1;
         rrdy   = 1'($urandom_range(0, 1));
         set_ready(rrdy);
         send_frame(rd, rst_ok, rpo, -1);
         idle(rst_ok ? $urandom_range(0, 12) : $urandom_range(4, 12));
      end
      set_ready(1'b1);
      idle(20);
      check_stream("random");
      check_counts("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
